// File: rtl/delay_timer_pkg.sv
// Shared types for the delay_timer block: mode encoding, FSM states and
// a helper that says which states drive the output active.
package delay_timer_pkg;

  typedef enum logic [1:0] {
    MODE_DLY_OP  = 2'b00,
    MODE_DLY_REL = 2'b01,
    MODE_DUAL    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ON_DLY  = 3'd1,
    ACTIVE  = 3'd2,
    OFF_DLY = 3'd3,
    PULSE   = 3'd4
  } state_e;

  // States in which delay_out_n is driven low.
  function automatic logic out_asserted(input state_e s);
    return (s == ACTIVE) || (s == OFF_DLY) || (s == PULSE);
  endfunction

endpackage

// File: rtl/delay_timer_sync.sv
// Two-flop synchronizer for the asynchronous trigger input.
module delay_timer_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/delay_timer.sv
// Programmable delay timer: synchronized trigger, edge detect, down-counter
// and mode FSM producing a registered active-low output.
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int unsigned WEIGHT_BIT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        trigger_in,
  input  logic                        mode_a,
  input  logic                        mode_b,
  input  logic [WEIGHT_BIT_WIDTH-1:0] weighted_bits,
  output logic                        delay_out_n
);

  localparam int unsigned W = WEIGHT_BIT_WIDTH;

  logic         trig_s;
  logic         trig_dly_q, trig_dly_d;
  logic         rise_c;
  state_e       state_q, state_d;
  mode_e        mode_q, mode_d;
  mode_e        mode_c;
  logic [W-1:0] cnt_q, cnt_d;
  logic         out_n_q, out_n_d;
  logic [W-1:0] w_eff_c;
  logic [W-1:0] w_load_c;
  logic         w_one_c;
  logic         cnt_last_c;

  delay_timer_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (trigger_in),
    .q     (trig_s)
  );

  assign rise_c     = trig_s & ~trig_dly_q;
  assign mode_c     = mode_e'({mode_b, mode_a});
  assign w_eff_c    = (weighted_bits == '0) ? W'(1) : weighted_bits;
  assign w_one_c    = (w_eff_c == W'(1));
  // The entry edge itself is the first cycle of the interval.
  assign w_load_c   = w_eff_c - W'(1);
  assign cnt_last_c = (cnt_q == W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_c;
    trig_dly_d = trig_s;

    if ((state_q != IDLE) && (mode_c != mode_q)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise_c) begin
            case (mode_c)
              MODE_DLY_OP, MODE_DUAL: begin
                if (w_one_c) begin
                  state_d = ACTIVE;
                end else begin
                  state_d = ON_DLY;
                  cnt_d   = w_load_c;
                end
              end
              MODE_DLY_REL: state_d = ACTIVE;
              MODE_ONESHOT: begin
                state_d = PULSE;
                cnt_d   = w_load_c;
              end
              default: state_d = IDLE;
            endcase
          end
        end
        ON_DLY: begin
          if (!trig_s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_last_c) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
        ACTIVE: begin
          cnt_d = '0;
          if (!trig_s) begin
            if ((mode_c == MODE_DLY_OP) || (mode_c == MODE_ONESHOT) || w_one_c) begin
              state_d = IDLE;
            end else begin
              state_d = OFF_DLY;
              cnt_d   = w_load_c;
            end
          end
        end
        OFF_DLY: begin
          if (trig_s) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else if (cnt_last_c) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    out_n_d = ~out_asserted(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE_DLY_OP;
      cnt_q      <= '0;
      trig_dly_q <= 1'b0;
      out_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      trig_dly_q <= trig_dly_d;
      out_n_q    <= out_n_d;
    end
  end

  assign delay_out_n = out_n_q;

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer: table of trigger waveforms with
// hand-computed output windows, plus reset / mode-change / reload sequences.
module tb_delay_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trigger_in;
  logic       mode_a;
  logic       mode_b;
  logic [7:0] weighted_bits;
  logic       delay_out_n;

  int n_cmp  = 0;
  int n_fail = 0;

  delay_timer #(.WEIGHT_BIT_WIDTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trigger_in    (trigger_in),
    .mode_a        (mode_a),
    .mode_b        (mode_b),
    .weighted_bits (weighted_bits),
    .delay_out_n   (delay_out_n)
  );

  always #5 clk = ~clk;

  // Waveform: high p1, low g, high p2, then low. Index t is the trigger
  // level sampled at edge S0+t; expectations are over the output after
  // edges S0+0 .. S0+59.
  typedef struct {
    logic [1:0] mode;
    logic [7:0] w;
    int         p1;
    int         g;
    int         p2;
    int         exp_first;
    int         exp_cnt;
    int         exp_runs;
  } vec_t;

  localparam int NVEC = 13;
  localparam int NCYC = 60;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    int   first;
    int   cnt;
    int   runs;
    logic prev;
    logic lvl;
    vec_t v;
    v = vecs[idx];
    {mode_b, mode_a} = v.mode;
    weighted_bits    = v.w;
    trigger_in       = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    first = -1;
    cnt   = 0;
    runs  = 0;
    prev  = 1'b1;
    for (int t = 0; t < NCYC; t++) begin
      lvl = (t < v.p1) || ((t >= v.p1 + v.g) && (t < v.p1 + v.g + v.p2));
      trigger_in = lvl;
      @(posedge clk);
      #1;
      if (delay_out_n == 1'b0) begin
        cnt++;
        if (first < 0) first = t;
        if (prev == 1'b1) runs++;
      end
      prev = delay_out_n;
    end
    check($sformatf("vec%0d first_low", idx), first, v.exp_first);
    check($sformatf("vec%0d low_cycles", idx), cnt, v.exp_cnt);
    check($sformatf("vec%0d low_runs", idx), runs, v.exp_runs);
  endtask

  // Counts edges from now until the output goes low; -1 if it never does.
  task automatic edges_to_low(input int limit, output int k_low);
    k_low = -1;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      if (delay_out_n == 1'b0) begin
        k_low = k;
        break;
      end
    end
  endtask

  initial begin
    int k;

    vecs[0]  = '{2'b00, 8'd10, 15, 0,  0, 11,  6, 1};
    vecs[1]  = '{2'b00, 8'd10,  2, 0,  0, -1,  0, 0};
    vecs[2]  = '{2'b01, 8'd10,  5, 0,  0,  2, 14, 1};
    vecs[3]  = '{2'b01, 8'd10,  5, 2,  5,  2, 21, 1};
    vecs[4]  = '{2'b10, 8'd10, 30, 2,  5, 11, 37, 1};
    vecs[5]  = '{2'b10, 8'd10,  5, 0,  0, -1,  0, 0};
    vecs[6]  = '{2'b11, 8'd10,  2, 2,  2,  2, 10, 1};
    vecs[7]  = '{2'b11, 8'd10, 20, 0,  0,  2, 10, 1};
    vecs[8]  = '{2'b11, 8'd10,  2, 14, 2,  2, 20, 2};
    vecs[9]  = '{2'b11, 8'd0,   3, 0,  0,  2,  1, 1};
    vecs[10] = '{2'b00, 8'd1,   5, 0,  0,  2,  5, 1};
    vecs[11] = '{2'b01, 8'd0,   3, 0,  0,  2,  3, 1};
    vecs[12] = '{2'b10, 8'd3,   3, 0,  0,  4,  3, 1};

    rst_n         = 1'b0;
    trigger_in    = 1'b0;
    mode_a        = 1'b0;
    mode_b        = 1'b0;
    weighted_bits = 8'd10;
    repeat (3) @(posedge clk);
    #1;
    check("reset delay_out_n", int'(delay_out_n), 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle after reset", int'(delay_out_n), 1);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Async reset while asserted, then re-assertion with trigger held high.
    {mode_b, mode_a} = 2'b00;
    weighted_bits    = 8'd10;
    trigger_in       = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("asserted before reset", int'(delay_out_n), 0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset output", int'(delay_out_n), 1);
    repeat (10) @(posedge clk);
    #1;
    check("held in reset", int'(delay_out_n), 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    edges_to_low(50, k);
    check("reassert after reset edge", k, 11);

    // W change mid-interval is ignored until the next interval.
    trigger_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    trigger_in = 1'b1;
    k = -1;
    for (int e = 0; e < 50; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) weighted_bits = 8'd3;
      if (delay_out_n == 1'b0) begin
        k = e;
        break;
      end
    end
    check("latched W assert edge", k, 11);

    // Mode change while ACTIVE forces release on the next edge.
    trigger_in = 1'b0;
    weighted_bits = 8'd5;
    repeat (20) @(posedge clk);
    #1;
    {mode_b, mode_a} = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    trigger_in = 1'b1;
    edges_to_low(20, k);
    check("mode01 immediate assert edge", k, 2);
    {mode_b, mode_a} = 2'b00;
    @(posedge clk);
    #1;
    check("mode change release", int'(delay_out_n), 1);
    repeat (20) @(posedge clk);
    #1;
    check("no refire without new rise", int'(delay_out_n), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
